snoop_ext_bus_table: RTL

SNOOP_EXT_BUS_TABLE -- requirements
Module: snoop_ext_bus_table

---
 rtl/snoop_bus_pkg.sv | 14 +
 rtl/snoop_ext_bus_table_if.sv | 29 ++
 rtl/snoop_bus_range_match.sv | 13 +
 rtl/snoop_ext_bus_table.sv | 126 ++++++++++++
 4 files changed

// File: rtl/snoop_bus_pkg.sv
// Shared types for the extended-config bus-number snoop table.
package snoop_bus_pkg;

    typedef logic [7:0] bus_num_t;

    typedef struct packed {
        bus_num_t pri;
        bus_num_t sec;
        bus_num_t sub;
    } bus_triplet_t;

    localparam logic [9:0] BUS_REG_ADDR_DEF = 10'h6;

endpackage

// File: rtl/snoop_ext_bus_table_if.sv
// Extended config write snoop channel plus the bus-number lookup handshake.
interface snoop_ext_bus_table_if #(
    parameter int FUNC_W = 2
);
    logic              usp_cfg_ext_write_received;
    logic [9:0]        usp_cfg_ext_register_number;
    logic [7:0]        usp_cfg_ext_function_number;
    logic [31:0]       usp_cfg_ext_write_data;
    logic [3:0]        usp_cfg_ext_write_byte_enable;
    logic              lookup_req;
    logic [7:0]        lookup_bus;
    logic              lookup_rsp_valid;
    logic              lookup_hit;
    logic [FUNC_W-1:0] lookup_func;

    modport master (
        output usp_cfg_ext_write_received, usp_cfg_ext_register_number,
               usp_cfg_ext_function_number, usp_cfg_ext_write_data,
               usp_cfg_ext_write_byte_enable, lookup_req, lookup_bus,
        input  lookup_rsp_valid, lookup_hit, lookup_func
    );

    modport slave (
        input  usp_cfg_ext_write_received, usp_cfg_ext_register_number,
               usp_cfg_ext_function_number, usp_cfg_ext_write_data,
               usp_cfg_ext_write_byte_enable, lookup_req, lookup_bus,
        output lookup_rsp_valid, lookup_hit, lookup_func
    );
endinterface

// File: rtl/snoop_bus_range_match.sv
// Single-function check: does bus fall inside this function's sec..sub window.
module snoop_bus_range_match
    import snoop_bus_pkg::*;
(
    input  bus_triplet_t triplet,
    input  logic         valid,
    input  bus_num_t     bus,
    output logic         match
);

    assign match = valid && (bus >= triplet.sec) && (bus <= triplet.sub);

endmodule

// File: rtl/snoop_ext_bus_table.sv
// Snoops bus-number config writes per function and routes bus numbers to the
// owning function with a one-cycle registered lookup.
module snoop_ext_bus_table
    import snoop_bus_pkg::*;
#(
    parameter int         NUM_FUNC     = 4,
    parameter logic [9:0] BUS_REG_ADDR = BUS_REG_ADDR_DEF,
    parameter int         CNT_W        = 16
) (
    input  logic                    usp_user_clk,
    input  logic                    sys_reset_n,
    snoop_ext_bus_table_if.slave    ext,
    output logic [8*NUM_FUNC-1:0]   bus_pri,
    output logic [8*NUM_FUNC-1:0]   bus_sec,
    output logic [8*NUM_FUNC-1:0]   bus_sub,
    output logic [NUM_FUNC-1:0]     func_bus_ready,
    output logic [NUM_FUNC-1:0]     func_range_valid,
    output logic [NUM_FUNC-1:0]     bus_update_pulse,
    output logic [CNT_W-1:0]        write_event_count
);

    localparam int FUNC_W = (NUM_FUNC > 1) ? $clog2(NUM_FUNC) : 1;

    bus_triplet_t        tbl_q [NUM_FUNC];
    bus_triplet_t        tbl_d [NUM_FUNC];
    logic [2:0]          rdy_q [NUM_FUNC];
    logic [2:0]          rdy_d [NUM_FUNC];
    logic [NUM_FUNC-1:0] match;
    logic                accept;
    logic [FUNC_W-1:0]   wr_idx;
    logic [FUNC_W-1:0]   hit_idx;
    logic                hit_any;
    logic                unused_bits;

    assign accept = ext.usp_cfg_ext_write_received
                 && (ext.usp_cfg_ext_register_number == BUS_REG_ADDR)
                 && (ext.usp_cfg_ext_function_number < 8'(NUM_FUNC));
    assign wr_idx = ext.usp_cfg_ext_function_number[FUNC_W-1:0];
    assign unused_bits = ^{ext.usp_cfg_ext_write_data[31:24], ext.usp_cfg_ext_write_byte_enable[3]};

    always_comb begin
        for (int f = 0; f < NUM_FUNC; f++) begin
            tbl_d[f] = tbl_q[f];
            rdy_d[f] = rdy_q[f];
            if (accept && (wr_idx == FUNC_W'(f))) begin
                if (ext.usp_cfg_ext_write_byte_enable[0]) begin
                    tbl_d[f].pri = ext.usp_cfg_ext_write_data[7:0];
                    rdy_d[f][0]  = 1'b1;
                end
                if (ext.usp_cfg_ext_write_byte_enable[1]) begin
                    tbl_d[f].sec = ext.usp_cfg_ext_write_data[15:8];
                    rdy_d[f][1]  = 1'b1;
                end
                if (ext.usp_cfg_ext_write_byte_enable[2]) begin
                    tbl_d[f].sub = ext.usp_cfg_ext_write_data[23:16];
                    rdy_d[f][2]  = 1'b1;
                end
            end
        end
    end

    // Status flags are derived from the next-state table so they move with it.
    always_ff @(posedge usp_user_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            for (int f = 0; f < NUM_FUNC; f++) begin
                tbl_q[f] <= '0;
                rdy_q[f] <= '0;
            end
            func_bus_ready   <= '0;
            func_range_valid <= '0;
            bus_update_pulse <= '0;
        end else begin
            for (int f = 0; f < NUM_FUNC; f++) begin
                tbl_q[f]            <= tbl_d[f];
                rdy_q[f]            <= rdy_d[f];
                func_bus_ready[f]   <= &rdy_d[f];
                func_range_valid[f] <= (&rdy_d[f]) && (tbl_d[f].sec != 8'd0)
                                       && (tbl_d[f].sec <= tbl_d[f].sub);
                bus_update_pulse[f] <= (tbl_d[f] != tbl_q[f]);
            end
        end
    end

    for (genvar g = 0; g < NUM_FUNC; g++) begin : g_func
        assign bus_pri[8*g +: 8] = tbl_q[g].pri;
        assign bus_sec[8*g +: 8] = tbl_q[g].sec;
        assign bus_sub[8*g +: 8] = tbl_q[g].sub;

        snoop_bus_range_match u_match (
            .triplet (tbl_q[g]),
            .valid   (func_range_valid[g]),
            .bus     (ext.lookup_bus),
            .match   (match[g])
        );
    end

    always_comb begin
        hit_any = |match;
        hit_idx = '0;
        for (int f = NUM_FUNC - 1; f >= 0; f--) begin
            if (match[f]) hit_idx = FUNC_W'(f);
        end
    end

    // Compare uses the registered table, so a same-cycle write is not yet visible.
    always_ff @(posedge usp_user_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            ext.lookup_rsp_valid <= 1'b0;
            ext.lookup_hit       <= 1'b0;
            ext.lookup_func      <= '0;
        end else begin
            ext.lookup_rsp_valid <= ext.lookup_req;
            ext.lookup_hit       <= ext.lookup_req && hit_any;
            ext.lookup_func      <= ext.lookup_req ? hit_idx : '0;
        end
    end

    always_ff @(posedge usp_user_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            write_event_count <= '0;
        end else if (accept && (write_event_count != {CNT_W{1'b1}})) begin
            write_event_count <= write_event_count + 1'b1;
        end
    end

endmodule
